bcd_to_binary: RTL and testbench
================================

Name: bcd_to_binary

Overview:
- Sequential packed-BCD to unsigned binary converter using reverse double dabble: shift right, then subtract-3 correction on each digit.
- Companion to the binary-to-BCD converter. Used wherever decimal-entered values (keypad, display registers, host commands) must return to binary for the arithmetic datapath.
- One digit is corrected per clock, so area stays minimal and latency is fixed and deterministic.

Parameters:
- DECIMAL_DIGITS, default 4: number of packed BCD input digits; digit 0 is bits [3:0].
- OUTPUT_WIDTH, default 14: binary result width; must be at least 1.

Ports:
- i_Clock  input  1  single clock; all logic acts on its rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_BCD  input  DECIMAL_DIGITS*4  packed BCD operand; sampled only when the start is accepted.
- i_Start  input  1  start request; accepted only in s_IDLE.
- o_Binary  output  OUTPUT_WIDTH  converted result; held until the next o_DV.
- o_DV  output  1  one-cycle pulse when o_Binary and o_Error are valid.
- o_Error  output  1  set with o_DV when any input digit is above 9 or the value does not fit in OUTPUT_WIDTH.
- o_Busy  output  1  high whenever the state is not s_IDLE.

Behaviour:
- Reset (synchronous, i_Reset high at a rising edge):
  - State goes to s_IDLE.
  - o_Binary=0, o_DV=0, o_Error=0, o_Busy=0.
  - Internal shift registers, loop counter and digit index clear.
  - Reset has priority over i_Start.
- Registers:
  - r_BCD: DECIMAL_DIGITS*4 bits.
  - r_Bin: OUTPUT_WIDTH bits.
  - r_Loop_Count: counts 0..OUTPUT_WIDTH-1.
  - r_Digit_Index: counts 0..DECIMAL_DIGITS-1.
  - r_Invalid: invalid-digit flag.
- s_IDLE:
  - o_DV driven 0.
  - On i_Start: r_BCD<=i_BCD, r_Bin<=0, r_Invalid<=(any input digit > 9), go to s_SHIFT.
- s_SHIFT (1 cycle):
  - Shift {r_BCD,r_Bin} right by one as one vector; r_BCD bit 0 moves to r_Bin MSB, and r_BCD MSB fills with 0.
  - Go to s_CORRECT.
- s_CORRECT (1 cycle per digit):
  - If digit[r_Digit_Index] >= 8, subtract 3 from it (4-bit, no carry to neighbouring digits).
  - If r_Digit_Index==DECIMAL_DIGITS-1: index<=0, go to s_CHECK_SHIFT_INDEX.
  - Otherwise index++ and stay in s_CORRECT.
- s_CHECK_SHIFT_INDEX (1 cycle):
  - If r_Loop_Count==OUTPUT_WIDTH-1: count<=0, go to s_DONE.
  - Otherwise count++ and go to s_SHIFT.
- s_DONE (1 cycle):
  - o_Binary<=r_Bin.
  - o_Error<=r_Invalid OR (r_BCD != 0); a nonzero residual means overflow.
  - o_DV<=1, go to s_IDLE.
- Latency:
  - o_DV rises exactly OUTPUT_WIDTH*(DECIMAL_DIGITS+2)+1 rising edges after the edge that accepted i_Start; this is 85 edges at the defaults.
  - o_DV is high for exactly one cycle.
- Handshake and boundary rules:
  - i_Start while o_Busy=1 is ignored; no queueing, and the in-flight operation is unaffected.
  - i_Start in the same cycle as o_DV=1 is accepted (back-to-back); the state is s_IDLE and o_DV drops on that edge.
  - i_BCD changes after acceptance have no effect.
  - When o_Error=1, o_Binary is don't-care.
  - Reset mid-conversion aborts it with no o_DV, and the next i_Start converts normally.
  - All-zero input gives a result of 0 with o_Error=0.
- Counter widths:
  - r_Loop_Count wide enough to hold OUTPUT_WIDTH-1.
  - r_Digit_Index wide enough to hold DECIMAL_DIGITS-1; minimum 1 bit.

Test Plan:
- Defaults; i_BCD=16'h1234, pulse i_Start -> o_Busy high; o_DV high for one cycle exactly 85 edges later; o_Binary=14'd1234 (0x4D2); o_Error=0.
- Sweep boundaries i_BCD=16'h0000, 16'h0009, 16'h0010, 16'h9999 -> o_Binary=0, 9, 10, 9999 (0x270F); o_Error=0 for all.
- i_BCD=16'h00A5 (digit 1 = 0xA) -> o_DV with o_Error=1.
- Overflow: DECIMAL_DIGITS=2, OUTPUT_WIDTH=6; i_BCD=8'h99 -> o_Error=1. Same configuration with i_BCD=8'h63 -> o_Binary=63, o_Error=0.
- Start 16'h0042; pulse i_Start with 16'h0777 mid-conversion -> only one o_DV, result 42. Then assert i_Start in the o_DV cycle with 16'h0777 -> a second o_DV 85 edges later with 777.
- Start 16'h5555; assert i_Reset at cycle 30 -> outputs 0, no o_DV. Then convert 16'h0100 -> 100.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Purpose: packed-BCD to unsigned binary converter using reverse double dabble, one digit corrected per clock.
// Latency: o_DV pulses OUTPUT_WIDTH*(DECIMAL_DIGITS+2)+1 edges after the edge that accepts i_Start.
// Backpressure: none; i_Start is ignored while o_Busy is high, and results are not queued.
//
// Ports:
//   i_Clock   - single clock, rising edge
//   i_Reset   - synchronous, active-high reset (priority over i_Start)
//   i_BCD     - packed BCD operand, digit 0 in bits [3:0]; sampled only on accepted start
//   i_Start   - start request, accepted only in s_IDLE
//   o_Binary  - converted result, held until the next o_DV
//   o_DV      - one-cycle pulse marking o_Binary/o_Error valid
//   o_Error   - invalid input digit (>9) or result does not fit in OUTPUT_WIDTH
//   o_Busy    - high whenever a conversion is in progress
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 4,
    parameter int OUTPUT_WIDTH   = 14
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
    input  logic                          i_Start,
    output logic [OUTPUT_WIDTH-1:0]       o_Binary,
    output logic                          o_DV,
    output logic                          o_Error,
    output logic                          o_Busy
);

    localparam int BCD_W  = DECIMAL_DIGITS * 4;
    // Counters are at least one bit wide so single-step configurations still elaborate.
    localparam int LOOP_W = (OUTPUT_WIDTH   > 1) ? $clog2(OUTPUT_WIDTH)   : 1;
    localparam int DIG_W  = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

    localparam logic [LOOP_W-1:0] LOOP_LAST  = LOOP_W'(OUTPUT_WIDTH - 1);
    localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(DECIMAL_DIGITS - 1);

    typedef enum logic [2:0] {
        s_IDLE,
        s_SHIFT,
        s_CORRECT,
        s_CHECK_SHIFT_INDEX,
        s_DONE
    } state_t;

    state_t                r_State,       nxt_State;
    logic [BCD_W-1:0]      r_BCD,         nxt_BCD;
    logic [OUTPUT_WIDTH-1:0] r_Bin,       nxt_Bin;
    logic [LOOP_W-1:0]     r_Loop_Count,  nxt_Loop_Count;
    logic [DIG_W-1:0]      r_Digit_Index, nxt_Digit_Index;
    logic                  r_Invalid,     nxt_Invalid;
    logic [OUTPUT_WIDTH-1:0] r_Binary,    nxt_Binary;
    logic                  r_DV,          nxt_DV;
    logic                  r_Error,       nxt_Error;

    logic [3:0]            digit_cur;
    int unsigned           digit_lsb;

    function automatic logic any_digit_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State       <= s_IDLE;
            r_BCD         <= '0;
            r_Bin         <= '0;
            r_Loop_Count  <= '0;
            r_Digit_Index <= '0;
            r_Invalid     <= 1'b0;
            r_Binary      <= '0;
            r_DV          <= 1'b0;
            r_Error       <= 1'b0;
        end else begin
            r_State       <= nxt_State;
            r_BCD         <= nxt_BCD;
            r_Bin         <= nxt_Bin;
            r_Loop_Count  <= nxt_Loop_Count;
            r_Digit_Index <= nxt_Digit_Index;
            r_Invalid     <= nxt_Invalid;
            r_Binary      <= nxt_Binary;
            r_DV          <= nxt_DV;
            r_Error       <= nxt_Error;
        end
    end

    always_comb begin
        nxt_State       = r_State;
        nxt_BCD         = r_BCD;
        nxt_Bin         = r_Bin;
        nxt_Loop_Count  = r_Loop_Count;
        nxt_Digit_Index = r_Digit_Index;
        nxt_Invalid     = r_Invalid;
        nxt_Binary      = r_Binary;
        nxt_DV          = 1'b0;
        nxt_Error       = r_Error;

        digit_lsb = 32'(r_Digit_Index) << 2;
        digit_cur = r_BCD[digit_lsb +: 4];

        case (r_State)
            s_IDLE: begin
                if (i_Start) begin
                    nxt_BCD     = i_BCD;
                    nxt_Bin     = '0;
                    nxt_Invalid = any_digit_invalid(i_BCD);
                    nxt_State   = s_SHIFT;
                end
            end

            s_SHIFT: begin
                // BCD and binary shift as one vector: BCD LSB enters the binary MSB.
                {nxt_BCD, nxt_Bin} = {r_BCD, r_Bin} >> 1;
                nxt_State          = s_CORRECT;
            end

            s_CORRECT: begin
                // A digit >= 8 after a right shift carried a 10 from its upper neighbour
                // that should only be worth 5; subtracting 3 restores decimal weight.
                if (digit_cur >= 4'd8) begin
                    nxt_BCD[digit_lsb +: 4] = digit_cur - 4'd3;
                end
                if (r_Digit_Index == DIGIT_LAST) begin
                    nxt_Digit_Index = '0;
                    nxt_State       = s_CHECK_SHIFT_INDEX;
                end else begin
                    nxt_Digit_Index = r_Digit_Index + 1'b1;
                end
            end

            s_CHECK_SHIFT_INDEX: begin
                if (r_Loop_Count == LOOP_LAST) begin
                    nxt_Loop_Count = '0;
                    nxt_State      = s_DONE;
                end else begin
                    nxt_Loop_Count = r_Loop_Count + 1'b1;
                    nxt_State      = s_SHIFT;
                end
            end

            s_DONE: begin
                nxt_Binary = r_Bin;
                // Anything left in the BCD register after all shifts did not fit the output.
                nxt_Error  = r_Invalid | (r_BCD != '0);
                nxt_DV     = 1'b1;
                nxt_State  = s_IDLE;
            end

            default: begin
                nxt_State = s_IDLE;
            end
        endcase
    end

    assign o_Binary = r_Binary;
    assign o_DV     = r_DV;
    assign o_Error  = r_Error;
    assign o_Busy   = (r_State != s_IDLE);

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

    logic i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    int cyc = 0;
    always @(posedge i_Clock) cyc <= cyc + 1;

    // Default configuration: 4 digits, 14-bit result, latency 85.
    logic        rst0, start0;
    logic [15:0] bcd0;
    logic [13:0] bin0;
    logic        dv0, err0, busy0;

    // Small configuration: 2 digits, 6-bit result, latency 6*4+1 = 25.
    logic        rst1, start1;
    logic [7:0]  bcd1;
    logic [5:0]  bin1;
    logic        dv1, err1, busy1;

    bcd_to_binary dut0 (
        .i_Clock (i_Clock),
        .i_Reset (rst0),
        .i_BCD   (bcd0),
        .i_Start (start0),
        .o_Binary(bin0),
        .o_DV    (dv0),
        .o_Error (err0),
        .o_Busy  (busy0)
    );

    bcd_to_binary #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(6)) dut1 (
        .i_Clock (i_Clock),
        .i_Reset (rst1),
        .i_BCD   (bcd1),
        .i_Start (start1),
        .o_Binary(bin1),
        .o_DV    (dv1),
        .o_Error (err1),
        .o_Busy  (busy1)
    );

    typedef struct {
        logic [13:0] bin;
        logic        err;
        bit          chk_bin;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Monitors: pop and compare every time a DUT presents o_DV.
    always @(negedge i_Clock) begin : mon0
        exp_t e;
        if (dv0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut0_unexpected_dv: got o_DV=1 required no pulse at cycle %0d", cyc);
            end else begin
                e = q0.pop_front();
                chk({e.name, "_latency"}, cyc, e.cyc);
                if (e.chk_bin) chk({e.name, "_binary"}, {18'd0, bin0}, {18'd0, e.bin});
                chk({e.name, "_error"}, {31'd0, err0}, {31'd0, e.err});
            end
        end
    end

    always @(negedge i_Clock) begin : mon1
        exp_t e;
        if (dv1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_dv: got o_DV=1 required no pulse at cycle %0d", cyc);
            end else begin
                e = q1.pop_front();
                chk({e.name, "_latency"}, cyc, e.cyc);
                if (e.chk_bin) chk({e.name, "_binary"}, {26'd0, bin1}, {18'd0, e.bin});
                chk({e.name, "_error"}, {31'd0, err1}, {31'd0, e.err});
            end
        end
    end

    // Called at a negedge; the following posedge accepts the start.
    task automatic go0(input string name, input logic [15:0] v, input logic [13:0] eb,
                       input logic ee, input bit cb);
        exp_t e;
        bcd0 = v;
        start0 = 1'b1;
        e.bin = eb; e.err = ee; e.chk_bin = cb; e.cyc = cyc + 1 + 85; e.name = name;
        q0.push_back(e);
        @(negedge i_Clock);
        start0 = 1'b0;
        bcd0 = ~v;  // later input changes must not disturb the conversion
        chk({name, "_busy"}, {31'd0, busy0}, 32'd1);
    endtask

    task automatic go1(input string name, input logic [7:0] v, input logic [13:0] eb,
                       input logic ee, input bit cb);
        exp_t e;
        bcd1 = v;
        start1 = 1'b1;
        e.bin = eb; e.err = ee; e.chk_bin = cb; e.cyc = cyc + 1 + 25; e.name = name;
        q1.push_back(e);
        @(negedge i_Clock);
        start1 = 1'b0;
        bcd1 = ~v;
        chk({name, "_busy"}, {31'd0, busy1}, 32'd1);
    endtask

    task automatic wait_dv0(input string name);
        int n;
        n = 0;
        do begin
            @(negedge i_Clock);
            n++;
        end while (dv0 !== 1'b1 && n < 200);
        if (dv0 !== 1'b1) chk({name, "_dv_timeout"}, {31'd0, dv0}, 32'd1);
    endtask

    task automatic wait_dv1(input string name);
        int n;
        n = 0;
        do begin
            @(negedge i_Clock);
            n++;
        end while (dv1 !== 1'b1 && n < 100);
        if (dv1 !== 1'b1) chk({name, "_dv_timeout"}, {31'd0, dv1}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
    } vec_t;

    vec_t sweep[4] = '{
        '{16'h0000, 14'd0},
        '{16'h0009, 14'd9},
        '{16'h0010, 14'd10},
        '{16'h9999, 14'd9999}
    };

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst0 = 1'b1; rst1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        bcd0 = 16'h0; bcd1 = 8'h0;
        repeat (3) @(negedge i_Clock);

        chk("rst_binary0", {18'd0, bin0},  32'd0);
        chk("rst_dv0",     {31'd0, dv0},   32'd0);
        chk("rst_error0",  {31'd0, err0},  32'd0);
        chk("rst_busy0",   {31'd0, busy0}, 32'd0);
        chk("rst_binary1", {26'd0, bin1},  32'd0);
        chk("rst_busy1",   {31'd0, busy1}, 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge i_Clock);

        // Basic conversion.
        go0("bcd_1234", 16'h1234, 14'd1234, 1'b0, 1'b1);
        wait_dv0("bcd_1234");
        @(negedge i_Clock);
        chk("dv_one_cycle", {31'd0, dv0}, 32'd0);

        // Boundary sweep.
        for (int i = 0; i < 4; i++) begin
            go0($sformatf("sweep_%04h", sweep[i].bcd), sweep[i].bcd, sweep[i].bin, 1'b0, 1'b1);
            wait_dv0("sweep");
            @(negedge i_Clock);
        end

        // Invalid digit.
        go0("bad_digit_00a5", 16'h00A5, 14'd0, 1'b1, 1'b0);
        wait_dv0("bad_digit");
        @(negedge i_Clock);

        // Small configuration: overflow and exact fit.
        go1("ovf_99", 8'h99, 14'd0, 1'b1, 1'b0);
        wait_dv1("ovf_99");
        @(negedge i_Clock);
        go1("fit_63", 8'h63, 14'd63, 1'b0, 1'b1);
        wait_dv1("fit_63");
        @(negedge i_Clock);

        // Start while busy is ignored; then back-to-back start in the o_DV cycle.
        go0("inflight_42", 16'h0042, 14'd42, 1'b0, 1'b1);
        repeat (20) @(negedge i_Clock);
        bcd0 = 16'h0777;
        start0 = 1'b1;
        @(negedge i_Clock);
        start0 = 1'b0;
        chk("ignored_start_busy", {31'd0, busy0}, 32'd1);
        wait_dv0("inflight_42");
        go0("b2b_777", 16'h0777, 14'd777, 1'b0, 1'b1);
        wait_dv0("b2b_777");
        @(negedge i_Clock);

        // Reset mid-conversion aborts with no o_DV.
        bcd0 = 16'h5555;
        start0 = 1'b1;
        @(negedge i_Clock);
        start0 = 1'b0;
        repeat (29) @(negedge i_Clock);
        rst0 = 1'b1;
        @(negedge i_Clock);
        rst0 = 1'b0;
        chk("midrst_binary", {18'd0, bin0},  32'd0);
        chk("midrst_error",  {31'd0, err0},  32'd0);
        chk("midrst_busy",   {31'd0, busy0}, 32'd0);
        repeat (100) @(negedge i_Clock);
        go0("after_rst_0100", 16'h0100, 14'd100, 1'b0, 1'b1);
        wait_dv0("after_rst");
        repeat (3) @(negedge i_Clock);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
